fib_checker: RTL
================

# fib_checker

Streaming monitor that sits directly downstream of the 4-bit Fibonacci counter and consumes its output one term per accepted cycle. It locks onto the wrapping sequence 0,1,1,2,3,5,8,0,1,…, reports lock, the index of the current term within the period, and the wrap point. It raises a one-cycle error pulse on any term that breaks the sequence while locked, then resynchronises automatically.

## Interface
- `W`, default 4: data width. Sequence wraps to 0 after any term with bit `W-1` set.
- `ERR_CNT_W`, default 8: error counter width. Used only with the macro.
- `clk` input 1: single clock, rising edge.
- `rst` input 1: asynchronous, active-low reset.
- `in_valid` input 1: `in_data` carries a term this cycle.
- `in_data` input W: upstream Fibonacci term.
- `locked` output 1: checker is tracking a valid sequence.
- `err` output 1: one-cycle pulse when a sequence violation occurs while locked.
- `wrap` output 1: one-cycle pulse when a locked 0 follows a term with MSB set.
- `term_idx` output 4: index of the last accepted term within the period; 0 for the 0 term.
- `err_count` output ERR_CNT_W: saturating violation count. Present only with the macro.

## Operation
- Internal registers:
  - `last`, `prev` (W bits each): the last two accepted terms.
  - `state`: one of HUNT, SEED, LOCKED.
- A sample is accepted only when `in_valid`=1. When `in_valid`=0:
  - all registers hold;
  - `err` and `wrap` are 0.
- Expected next term in LOCKED:
  - `last[W-1]`=1 → 0;
  - else `last`=0 → 1;
  - else `prev+last`, computed in W bits. This cannot overflow, because `last` < 2^(W-1) and `prev` ≤ `last`.
- HUNT:
  - data 0 → SEED, `term_idx`=0;
  - anything else → stay in HUNT.
- SEED:
  - data 1 → LOCKED, `locked`=1, `term_idx`=1;
  - data 0 → stay in SEED, `term_idx`=0;
  - anything else → HUNT.
  - No `err` is raised in HUNT or SEED.
- LOCKED, data matches expected:
  - `term_idx` increments, but resets to 0 on a 0 term;
  - `wrap`=1 if the 0 term follows a `last` with MSB set.
- LOCKED, data mismatches:
  - `err`=1 and `locked`=0;
  - next state is SEED with `term_idx`=0 if data=0, else HUNT.
- `last`/`prev` update on every accepted sample, in every state: `prev`←`last`, `last`←`in_data`.

## Timing
- All outputs are registered. Response appears on the first rising edge after the accepting edge, i.e. one cycle latency from sample to `locked`/`err`/`wrap`/`term_idx`.
- Reset (`rst`=0, asynchronous, any time including mid-lock):
  - state=HUNT;
  - `last`=`prev`=0;
  - `locked`=0, `err`=0, `wrap`=0, `term_idx`=0, `err_count`=0.
- Release of `rst` is synchronous to `clk`. The first sample accepted after release is evaluated in HUNT.
- `err` and `wrap` are never asserted in the same cycle.
- Back-to-back `in_valid` is fully supported: one term per cycle, no stalls, no backpressure.

## Configuration
- `FIB_CHECKER_ERRCNT_EN` defined:
  - the `err_count` port and register exist;
  - the counter increments on each `err` pulse and saturates at 2^ERR_CNT_W−1;
  - it clears only on reset.
- `FIB_CHECKER_ERRCNT_EN` undefined: no port, no counter logic. All other behaviour is identical.

## Structure
- Shared package `fib_pkg` holds:
  - state enum `fib_chk_state_t` (HUNT, SEED, LOCKED);
  - constant `FIB_W`=4;
  - constant `FIB_PERIOD`=7 (terms per period at W=4).
- One natural sub-module, `fib_next_term`: combinational expected-term generator from `last`/`prev` per the LOCKED rule above. The FSM, registers and counter stay in `fib_checker`.

## Test plan
- Clean stream 0,1,1,2,3,5,8,0,1,1, valid every cycle →
  - `locked` rises one cycle after the 2nd sample;
  - `term_idx` reads 1,2,3,4,5,6,0,1,2;
  - `wrap` pulses once, one cycle after the 8th sample;
  - `err` never asserts.
- Lock, then feed 0,1,1,2,4 →
  - `err` pulses one cycle after 4, `locked` drops, state HUNT;
  - a subsequent 0,1 relocks.
- Start mid-sequence 3,5,8,0,1,1 → no `err`; lock after the 0,1 pair; `term_idx`=2 after the final 1.
- Clean stream with `in_valid` low for 3 cycles between 5 and 8 → outputs hold during the gap; no `err`; `term_idx`=6 after 8.
- Assert `rst` low mid-lock at `term_idx`=4 → all outputs 0 immediately (asynchronous); after release, 0,1 relocks.
- Macro defined, `ERR_CNT_W`=2, force 5 violations (lock then corrupt, repeated) → `err_count` reads 1,2,3,3,3.

Source files
------------

// File: rtl/fib_pkg.sv
// Shared types and constants for the Fibonacci stream checker.
package fib_pkg;

    localparam int unsigned FIB_W      = 4;
    localparam int unsigned FIB_PERIOD = 7;

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        SEED   = 2'd1,
        LOCKED = 2'd2
    } fib_chk_state_t;

endpackage

// File: rtl/fib_next_term.sv
// Combinational expected-next-term generator for the wrapping Fibonacci sequence.
module fib_next_term #(
    parameter int unsigned W = 4
) (
    input  logic [W-1:0] last_i,
    input  logic [W-1:0] prev_i,
    output logic [W-1:0] exp_term_c
);

    // prev <= last < 2^(W-1) while MSB is clear, so the sum always fits in W bits
    always_comb begin
        exp_term_c = prev_i + last_i;
        if (last_i[W-1]) begin
            exp_term_c = '0;
        end else if (last_i == '0) begin
            exp_term_c = W'(1);
        end
    end

endmodule

// File: rtl/fib_checker.sv
// Streaming monitor that locks onto the wrapping Fibonacci sequence and flags violations.
// Optional saturating error counter enabled by defining FIB_CHECKER_ERRCNT_EN.
module fib_checker
    import fib_pkg::*;
#(
    parameter int unsigned W         = FIB_W,
    parameter int unsigned ERR_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    input  logic [W-1:0]         in_data,
    output logic                 locked,
    output logic                 err,
    output logic                 wrap,
    output logic [3:0]           term_idx
`ifdef FIB_CHECKER_ERRCNT_EN
    ,
    output logic [ERR_CNT_W-1:0] err_count
`endif
);

    localparam int unsigned IDX_W = 4;

    fib_chk_state_t   state_q, state_d;
    logic [W-1:0]     last_q, prev_q;
    logic [W-1:0]     exp_term;
    logic             match;
    logic             locked_q, locked_d;
    logic             err_q, err_d;
    logic             wrap_q, wrap_d;
    logic [IDX_W-1:0] term_idx_q, term_idx_d;

    fib_next_term #(.W(W)) u_next_term (
        .last_i     (last_q),
        .prev_i     (prev_q),
        .exp_term_c (exp_term)
    );

    assign match = (in_data == exp_term);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= HUNT;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (in_valid) begin
            case (state_q)
                HUNT: begin
                    if (in_data == '0) state_d = SEED;
                end
                SEED: begin
                    if (in_data == W'(1))     state_d = LOCKED;
                    else if (in_data != '0)   state_d = HUNT;
                end
                LOCKED: begin
                    if (!match) state_d = (in_data == '0) ? SEED : HUNT;
                end
                default: state_d = HUNT;
            endcase
        end
    end

    // Output next-values; idle cycles hold status and suppress pulses
    always_comb begin
        locked_d   = locked_q;
        term_idx_d = term_idx_q;
        err_d      = 1'b0;
        wrap_d     = 1'b0;
        if (in_valid) begin
            locked_d = (state_d == LOCKED);
            err_d    = (state_q == LOCKED) && !match;
            if ((state_q == LOCKED) && match) begin
                term_idx_d = (in_data == '0) ? '0 : term_idx_q + IDX_W'(1);
                wrap_d     = (in_data == '0) && last_q[W-1];
            end else if (state_d == LOCKED) begin
                term_idx_d = IDX_W'(1);
            end else begin
                term_idx_d = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_q     <= '0;
            prev_q     <= '0;
            locked_q   <= 1'b0;
            err_q      <= 1'b0;
            wrap_q     <= 1'b0;
            term_idx_q <= '0;
        end else begin
            if (in_valid) begin
                prev_q <= last_q;
                last_q <= in_data;
            end
            locked_q   <= locked_d;
            err_q      <= err_d;
            wrap_q     <= wrap_d;
            term_idx_q <= term_idx_d;
        end
    end

    assign locked   = locked_q;
    assign err      = err_q;
    assign wrap     = wrap_q;
    assign term_idx = term_idx_q;

`ifdef FIB_CHECKER_ERRCNT_EN
    logic [ERR_CNT_W-1:0] err_cnt_q;

    // Saturating count, updated on the same edge that raises err
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_cnt_q <= '0;
        end else if (err_d && (err_cnt_q != '1)) begin
            err_cnt_q <= err_cnt_q + ERR_CNT_W'(1);
        end
    end

    assign err_count = err_cnt_q;
`else
    logic [31:0] unused_err_cnt_w;
    assign unused_err_cnt_w = 32'(ERR_CNT_W);
`endif

endmodule
